// File: rtl/spi_resp_regfile.sv
// SPI mode-3 responder fronting a 16x8 register file.
// SPI pins are oversampled in the clk domain; frames are R/W, addr[6:0], data[7:0].
module spi_resp_regfile #(
    parameter logic [6:0] WHO_AM_I_ADDR = 7'h75,
    parameter logic [7:0] WHO_AM_I_VAL  = 8'h70
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       spi_csn,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic       host_we,
    input  logic [3:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       rx_valid,
    output logic       rx_rw,
    output logic [6:0] rx_addr,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic       busy
);

    logic [2:0]  csn_q;
    logic [2:0]  sclk_q;
    logic [1:0]  mosi_q;
    logic        csn_s;
    logic        csn_rise;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        mosi_s;

    logic [7:0]  regs [16];
    logic [4:0]  bit_cnt;
    logic [15:0] shift;
    logic [7:0]  rd_val;
    logic [7:0]  rd_sh;
    logic        done;
    logic        err_pend;

    logic [6:0]  addr8;
    logic [7:0]  rd_lookup;
    logic [7:0]  wdata;
    logic        wr_hit;

    // Bit [1] is the synchronized level, bit [2] the edge reference.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            csn_q  <= 3'b111;
            sclk_q <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            csn_q  <= {csn_q[1:0], spi_csn};
            sclk_q <= {sclk_q[1:0], spi_clk};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    assign csn_s     = csn_q[1];
    assign csn_rise  = csn_q[1] & ~csn_q[2];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign mosi_s    = mosi_q[1];
    assign busy      = ~csn_s;

    // Address as it stands once the 8th bit lands.
    assign addr8 = {shift[5:0], mosi_s};
    assign wdata = {shift[6:0], mosi_s};
    assign wr_hit = ~shift[14] && (shift[13:11] == 3'b000);

    always_comb begin
        rd_lookup = 8'h00;
        if (addr8[6:4] == 3'b000)
            rd_lookup = regs[addr8[3:0]];
        else if (addr8 == WHO_AM_I_ADDR)
            rd_lookup = WHO_AM_I_VAL;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 16; i++)
                regs[i] <= 8'h00;
            bit_cnt   <= 5'd0;
            shift     <= 16'h0000;
            rd_val    <= 8'h00;
            rd_sh     <= 8'h00;
            done      <= 1'b0;
            err_pend  <= 1'b0;
            spi_miso  <= 1'b0;
            rx_valid  <= 1'b0;
            rx_rw     <= 1'b0;
            rx_addr   <= 7'h00;
            rx_data   <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            done      <= 1'b0;
            err_pend  <= 1'b0;
            rx_valid  <= done;
            frame_err <= err_pend;
            if (done) begin
                rx_rw   <= shift[15];
                rx_addr <= shift[14:8];
                rx_data <= shift[15] ? rd_val : shift[7:0];
            end
            if (host_we)
                regs[host_addr] <= host_wdata;
            if (csn_s) begin
                bit_cnt  <= 5'd0;
                rd_sh    <= 8'h00;
                spi_miso <= 1'b0;
                if (csn_rise && bit_cnt != 5'd0 && bit_cnt != 5'd16)
                    err_pend <= 1'b1;
            end else begin
                if (sclk_rise && bit_cnt != 5'd16) begin
                    shift   <= {shift[14:0], mosi_s};
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd7) begin
                        rd_val <= rd_lookup;
                        rd_sh  <= shift[6] ? rd_lookup : 8'h00;
                    end
                    if (bit_cnt == 5'd15) begin
                        done <= 1'b1;
                        // Placed after the host write so SPI wins a tie.
                        if (wr_hit)
                            regs[shift[10:7]] <= wdata;
                    end
                end
                if (sclk_fall) begin
                    spi_miso <= rd_sh[7];
                    rd_sh    <= {rd_sh[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_resp_regfile.sv
// Bench for spi_resp_regfile: directed table, corner sequences and
// random frames checked against an array model of the register file.
module tb_spi_resp_regfile;

    localparam int HALF = 6;

    logic       clk;
    logic       rstn;
    logic       spi_csn;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;
    logic       host_we;
    logic [3:0] host_addr;
    logic [7:0] host_wdata;
    logic       rx_valid;
    logic       rx_rw;
    logic [6:0] rx_addr;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       busy;

    spi_resp_regfile dut (
        .clk        (clk),
        .rstn       (rstn),
        .spi_csn    (spi_csn),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .rx_valid   (rx_valid),
        .rx_rw      (rx_rw),
        .rx_addr    (rx_addr),
        .rx_data    (rx_data),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_valid = 0;
    int n_err = 0;

    always @(negedge clk) begin
        if (rx_valid) n_valid++;
        if (frame_err) n_err++;
    end

    logic [7:0] mdl [16];

    typedef struct {
        logic [15:0] frame;
        int          nb;
        int          extra;
        logic        hwe;
        logic [3:0]  ha;
        logic [7:0]  hd;
        int          ev;
        int          ee;
        logic        erw;
        logic [6:0]  ea;
        logic [7:0]  ed;
        logic [15:0] emiso;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] mdl_rd(input logic [6:0] a);
        if (a < 7'd16) return mdl[a[3:0]];
        if (a == 7'h75) return 8'h70;
        return 8'h00;
    endfunction

    task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
        host_we = 1'b1;
        host_addr = a;
        host_wdata = d;
        @(posedge clk);
        #1;
        host_we = 1'b0;
    endtask

    // One SPI bit: falling edge drives mosi, miso sampled before rise.
    task automatic spi_bit(input logic b, input bit collide,
                           output logic m);
        spi_clk = 1'b0;
        spi_mosi = b;
        repeat (HALF) @(posedge clk);
        #1;
        m = spi_miso;
        spi_clk = 1'b1;
        if (collide) begin
            repeat (2) @(posedge clk);
            #1;
            host_we = 1'b1;
            host_addr = 4'h4;
            host_wdata = 8'hEE;
            @(posedge clk);
            #1;
            host_we = 1'b0;
            repeat (HALF - 3) @(posedge clk);
        end else begin
            repeat (HALF) @(posedge clk);
        end
        #1;
    endtask

    task automatic run_frame(input logic [15:0] f, input int nb,
                             input int extra, input bit collide,
                             output logic [15:0] cap);
        logic m;
        cap = 16'h0000;
        spi_csn = 1'b0;
        repeat (HALF) @(posedge clk);
        #1;
        for (int i = 0; i < nb; i++) begin
            spi_bit(f[15-i], collide && i == 15, m);
            cap[15-i] = m;
        end
        for (int i = 0; i < extra; i++)
            spi_bit(1'b0, 1'b0, m);
        spi_csn = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input logic [15:0] f,
                               input int nb, input int extra,
                               input int ev, input int ee,
                               input logic erw, input logic [6:0] ea,
                               input logic [7:0] ed,
                               input logic [15:0] emiso);
        int v0, e0;
        logic [15:0] cap;
        v0 = n_valid;
        e0 = n_err;
        run_frame(f, nb, extra, 1'b0, cap);
        chk({tag, " valid"}, n_valid - v0, ev);
        chk({tag, " err"}, n_err - e0, ee);
        chk({tag, " rw"}, rx_rw, erw);
        chk({tag, " addr"}, rx_addr, ea);
        chk({tag, " data"}, rx_data, ed);
        chk({tag, " miso"}, cap, emiso);
    endtask

    task automatic model_frame(input logic [15:0] f, input int nb);
        if (nb == 16 && !f[15] && f[14:8] < 7'd16)
            mdl[f[11:8]] = f[7:0];
    endtask

    logic        lrw;
    logic [6:0]  la;
    logic [7:0]  ld;

    initial begin
        logic [15:0] cap;
        int v0;
        rstn = 1'b0;
        spi_csn = 1'b1;
        spi_clk = 1'b1;
        spi_mosi = 1'b0;
        host_we = 1'b0;
        host_addr = 4'h0;
        host_wdata = 8'h00;
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst outs",
            {spi_miso, rx_valid, frame_err, busy, rx_rw, rx_addr, rx_data},
            32'h0);
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        tbl[0]  = '{16'h0355, 16, 0, 1'b0, 4'h0, 8'h00,
                    1, 0, 1'b0, 7'h03, 8'h55, 16'h0000};
        tbl[1]  = '{16'h8500, 16, 0, 1'b1, 4'h5, 8'hA7,
                    1, 0, 1'b1, 7'h05, 8'hA7, 16'h00A7};
        tbl[2]  = '{16'hF500, 16, 0, 1'b0, 4'h0, 8'h00,
                    1, 0, 1'b1, 7'h75, 8'h70, 16'h0070};
        tbl[3]  = '{16'h7512, 16, 0, 1'b0, 4'h0, 8'h00,
                    1, 0, 1'b0, 7'h75, 8'h12, 16'h0000};
        tbl[4]  = '{16'hF500, 16, 0, 1'b0, 4'h0, 8'h00,
                    1, 0, 1'b1, 7'h75, 8'h70, 16'h0070};
        tbl[5]  = '{16'h0799, 16, 3, 1'b0, 4'h0, 8'h00,
                    1, 0, 1'b0, 7'h07, 8'h99, 16'h0000};
        tbl[6]  = '{16'h8700, 16, 0, 1'b0, 4'h0, 8'h00,
                    1, 0, 1'b1, 7'h07, 8'h99, 16'h0099};
        tbl[7]  = '{16'h0233, 9, 0, 1'b0, 4'h0, 8'h00,
                    0, 1, 1'b1, 7'h07, 8'h99, 16'h0000};
        tbl[8]  = '{16'h8200, 16, 0, 1'b0, 4'h0, 8'h00,
                    1, 0, 1'b1, 7'h02, 8'h00, 16'h0000};
        tbl[9]  = '{16'h8300, 16, 0, 1'b0, 4'h0, 8'h00,
                    1, 0, 1'b1, 7'h03, 8'h55, 16'h0055};
        tbl[10] = '{16'hA000, 16, 0, 1'b0, 4'h0, 8'h00,
                    1, 0, 1'b1, 7'h20, 8'h00, 16'h0000};

        for (int k = 0; k < 11; k++) begin
            if (tbl[k].hwe) begin
                host_wr(tbl[k].ha, tbl[k].hd);
                mdl[tbl[k].ha] = tbl[k].hd;
            end
            check_frame($sformatf("vec%0d", k), tbl[k].frame, tbl[k].nb,
                        tbl[k].extra, tbl[k].ev, tbl[k].ee, tbl[k].erw,
                        tbl[k].ea, tbl[k].ed, tbl[k].emiso);
            model_frame(tbl[k].frame, tbl[k].nb);
        end

        // SPI write and host write commit on the same clk edge.
        v0 = n_valid;
        run_frame(16'h0411, 16, 0, 1'b1, cap);
        chk("tie valid", n_valid - v0, 1);
        mdl[4] = 8'h11;
        check_frame("tie rd", 16'h8400, 16, 0, 1, 0,
                    1'b1, 7'h04, 8'h11, 16'h0011);

        // Reset in the middle of a read frame.
        spi_csn = 1'b0;
        repeat (HALF) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            logic m;
            spi_bit(i == 0 ? 1'b1 : 1'b0, 1'b0, m);
        end
        chk("busy mid", busy, 1'b1);
        rstn = 1'b0;
        #2;
        chk("midrst outs",
            {spi_miso, rx_valid, frame_err, busy, rx_rw, rx_addr, rx_data},
            32'h0);
        spi_csn = 1'b1;
        spi_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_frame("post rd4", 16'h8400, 16, 0, 1, 0,
                    1'b1, 7'h04, 8'h00, 16'h0000);
        check_frame("post wr", 16'h0A5C, 16, 0, 1, 0,
                    1'b0, 7'h0A, 8'h5C, 16'h0000);
        mdl[10] = 8'h5C;
        check_frame("post rd", 16'h8A00, 16, 0, 1, 0,
                    1'b1, 7'h0A, 8'h5C, 16'h005C);
        lrw = 1'b1;
        la = 7'h0A;
        ld = 8'h5C;

        // Random frames against the array model.
        for (int k = 0; k < 30; k++) begin
            logic        rw;
            logic [6:0]  a;
            logic [7:0]  d;
            logic [7:0]  rd;
            logic [15:0] f;
            logic [15:0] full;
            logic [15:0] em;
            int          nb;
            int          ex;
            int          sel;
            if ($urandom_range(0, 2) == 0) begin
                logic [3:0] ha;
                logic [7:0] hd;
                ha = 4'($urandom_range(0, 15));
                hd = 8'($urandom);
                host_wr(ha, hd);
                mdl[ha] = hd;
            end
            rw = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel < 7) a = 7'($urandom_range(0, 15));
            else if (sel == 7) a = 7'h75;
            else a = 7'($urandom);
            d = 8'($urandom);
            nb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 15) : 16;
            ex = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            if (nb < 16) ex = 0;
            f = {rw, a, rw ? 8'h00 : d};
            rd = mdl_rd(a);
            full = {8'h00, rw ? rd : 8'h00};
            em = 16'h0000;
            for (int i = 0; i < nb; i++) em[15-i] = full[15-i];
            if (nb == 16) begin
                lrw = rw;
                la = a;
                ld = rw ? rd : d;
            end
            check_frame($sformatf("rnd%0d", k), f, nb, ex,
                        nb == 16 ? 1 : 0, nb == 16 ? 0 : 1,
                        lrw, la, ld, em);
            model_frame(f, nb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
